reduceron_run_ctrl: RTL and testbench
=====================================

// Module: reduceron_run_ctrl
// PURPOSE
//  Run sequencer for one Reduceron core instance. Holds the core in reset, releases it on a
//  host start, counts run cycles and watches finish. Tracks the heap high-water mark and
//  enforces an optional cycle timeout. Captures result/state/heap into a valid/ready result
//  port. Sits between the host/bench and the Reduceron core, replacing free-running operation.
// PARAMETERS
//  RST_CYCLES  4         cycles core_rst_n is held low before each run (>=1)
//  CNT_W       32        width of run-cycle counter
//  MAX_CYCLES  0         timeout in cycles; 0 = timeout disabled
// PORTS
//  clock         in   1      system clock, rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  start         in   1      pulse: begin a run (accepted only in IDLE, or in DONE with res_ready)
//  abort         in   1      level: kill current run, return to IDLE
//  core_rst_n    out  1      reset to Reduceron core, active low
//  core_finish   in   1      core finish flag
//  core_result   in   18     core result word r
//  core_state    in   7      core state s
//  core_heap     in   15     core heap pointer h
//  busy          out  1      high in RESET_CORE or RUN
//  res_valid     out  1      result available
//  res_ready     in   1      host accepts result
//  res_value     out  18     captured core_result
//  res_state     out  7      captured core_state
//  res_heap      out  15     captured core_heap at finish
//  res_heap_max  out  15     max core_heap sampled during RUN
//  res_cycles    out  CNT_W  RUN cycles up to and including finish/timeout cycle
//  res_timeout   out  1      1 = run ended by timeout, not finish
// BEHAVIOUR
//  Reset: FSM=IDLE; core_rst_n=0; busy=0; res_valid=0; all res_* =0. All outputs registered.
//  IDLE: core_rst_n=0. start -> RESET_CORE, rst counter=0, cycle counter=0, heap_max=0.
//  RESET_CORE: core_rst_n=0 for exactly RST_CYCLES cycles, then -> RUN (core_rst_n=1 next edge).
//    core_finish ignored here.
//  RUN: each cycle cycle_cnt+=1 (saturates at 2^CNT_W-1, no wrap); heap_max=max(heap_max,core_heap).
//    core_finish=1 -> capture res_value/state/heap, res_cycles=cycle_cnt incl. this cycle,
//    res_heap_max includes this cycle's heap, res_timeout=0, -> DONE.
//    Else if MAX_CYCLES!=0 and count reaches MAX_CYCLES -> capture, res_timeout=1, -> DONE.
//    finish and timeout same cycle: finish wins (res_timeout=0).
//  DONE: res_valid=1, core_rst_n=0 (core held). res_* stable while res_valid & !res_ready.
//    res_valid&res_ready -> IDLE; if start also high same cycle -> RESET_CORE directly
//    (res_valid drops next cycle, new run begins; no lost or duplicated result).
//  start in RESET_CORE/RUN or DONE without res_ready: ignored (not queued).
//  abort (any state, priority over everything except reset_n): -> IDLE next edge, core_rst_n=0,
//    res_valid=0, pending result discarded.
//  reset_n low mid-run: immediate async return to reset values; core_rst_n low asynchronously.
//  Latency: start -> core_rst_n high = RST_CYCLES+1 edges; finish -> res_valid = 1 edge.
// STRUCTURE
//  reduceron_pkg: RES_W=18, STATE_W=7, HEAP_W=15, run FSM enum {IDLE,RESET_CORE,RUN,DONE}.
//  Sub-module reduceron_cycle_counter: saturating CNT_W counter with clear/enable,
//  reused for both the reset-hold count and run-cycle count.
// TESTING
//  1 Reset, RST_CYCLES=4: start pulse -> core_rst_n low 4 cycles then high; busy=1 for 5 cycles.
//  2 Core model asserts finish after 100 RUN cycles, r=12345, h ramps 0..900 then 500 ->
//    res_valid, res_value=12345, res_cycles=100, res_heap=500, res_heap_max=900, res_timeout=0.
//  3 MAX_CYCLES=50, finish never -> res_timeout=1, res_cycles=50; finish at cycle 50 -> timeout=0.
//  4 res_ready low 10 cycles -> res_* stable, start ignored; ready+start same cycle ->
//    one handshake, new run begins, core_rst_n low RST_CYCLES again.
//  5 abort during RUN and during DONE -> IDLE next edge, res_valid=0, core_rst_n=0.
//  6 reset_n low mid-RUN (between clock edges) -> core_rst_n=0 at once; CNT_W=4 run of 20
//    cycles -> res_cycles=15 (saturated).

Source files
------------

// File: rtl/reduceron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduceron_pkg
// Brief    : Shared widths, run-FSM encoding and helpers for the run controller.
// Revision : 1.0
// ============================================================================
package reduceron_pkg;

    localparam int RES_W   = 18;
    localparam int STATE_W = 7;
    localparam int HEAP_W  = 15;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_CORE = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } run_state_e;

    function automatic logic [HEAP_W-1:0] heap_max(input logic [HEAP_W-1:0] a,
                                                   input logic [HEAP_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduceron_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module   : reduceron_cycle_counter
// Brief    : Saturating up-counter with clear/enable; exposes the next value.
// Revision : 1.0
// ============================================================================
module reduceron_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count_inc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // count_inc is what this cycle would make the count, so callers can act on it
    // in the same cycle it is reached.
    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + 1'b1;
        count_d   = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reduceron_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reduceron_run_ctrl
// Brief    : Holds a Reduceron core in reset, runs it, and captures its result.
// Revision : 1.0
// ============================================================================
module reduceron_run_ctrl
    import reduceron_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic               core_rst_n,
    input  logic               core_finish,
    input  logic [RES_W-1:0]   core_result,
    input  logic [STATE_W-1:0] core_state,
    input  logic [HEAP_W-1:0]  core_heap,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RES_W-1:0]   res_value,
    output logic [STATE_W-1:0] res_state,
    output logic [HEAP_W-1:0]  res_heap,
    output logic [HEAP_W-1:0]  res_heap_max,
    output logic [CNT_W-1:0]   res_cycles,
    output logic               res_timeout
);

    localparam int               RST_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES);

    run_state_e         state_q, state_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic [HEAP_W-1:0]  heap_max_q, heap_max_d;
    logic [RES_W-1:0]   res_value_q, res_value_d;
    logic [STATE_W-1:0] res_state_q, res_state_d;
    logic [HEAP_W-1:0]  res_heap_q, res_heap_d;
    logic [HEAP_W-1:0]  res_heap_max_q, res_heap_max_d;
    logic [CNT_W-1:0]   res_cycles_q, res_cycles_d;
    logic               res_timeout_q, res_timeout_d;

    logic               run_clr;
    logic               rst_en;
    logic               cyc_en;
    logic [RST_W-1:0]   rst_inc;
    logic [CNT_W-1:0]   cyc_inc;
    logic [HEAP_W-1:0]  run_heap_max;
    logic               timeout_hit;

    reduceron_cycle_counter #(.WIDTH(RST_W)) u_rst_cnt (
        .clk       (clock),
        .rst_n     (reset_n),
        .clr       (run_clr),
        .en        (rst_en),
        .count_inc (rst_inc)
    );

    reduceron_cycle_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
        .clk       (clock),
        .rst_n     (reset_n),
        .clr       (run_clr),
        .en        (cyc_en),
        .count_inc (cyc_inc)
    );

    generate
        if (MAX_CYCLES != 0) begin : g_timeout
            localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);
            assign timeout_hit = (cyc_inc == MAX_CNT);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        heap_max_d     = heap_max_q;
        res_value_d    = res_value_q;
        res_state_d    = res_state_q;
        res_heap_d     = res_heap_q;
        res_heap_max_d = res_heap_max_q;
        res_cycles_d   = res_cycles_q;
        res_timeout_d  = res_timeout_q;
        run_clr        = 1'b0;
        rst_en         = 1'b0;
        cyc_en         = 1'b0;
        run_heap_max   = heap_max(heap_max_q, core_heap);

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RESET_CORE;
                        run_clr = 1'b1;
                    end
                end
                ST_RESET_CORE: begin
                    rst_en = 1'b1;
                    if (rst_inc == RST_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cyc_en     = 1'b1;
                    heap_max_d = run_heap_max;
                    // Finish outranks a timeout landing on the same cycle.
                    if (core_finish || timeout_hit) begin
                        state_d        = ST_DONE;
                        res_value_d    = core_result;
                        res_state_d    = core_state;
                        res_heap_d     = core_heap;
                        res_heap_max_d = run_heap_max;
                        res_cycles_d   = cyc_inc;
                        res_timeout_d  = !core_finish;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        if (start) begin
                            state_d = ST_RESET_CORE;
                            run_clr = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (run_clr) begin
            heap_max_d = '0;
        end

        // Outputs are decoded from the next state so they register with it.
        core_rst_n_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RESET_CORE) || (state_d == ST_RUN);
        res_valid_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            core_rst_n_q   <= 1'b0;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            heap_max_q     <= '0;
            res_value_q    <= '0;
            res_state_q    <= '0;
            res_heap_q     <= '0;
            res_heap_max_q <= '0;
            res_cycles_q   <= '0;
            res_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            core_rst_n_q   <= core_rst_n_d;
            busy_q         <= busy_d;
            res_valid_q    <= res_valid_d;
            heap_max_q     <= heap_max_d;
            res_value_q    <= res_value_d;
            res_state_q    <= res_state_d;
            res_heap_q     <= res_heap_d;
            res_heap_max_q <= res_heap_max_d;
            res_cycles_q   <= res_cycles_d;
            res_timeout_q  <= res_timeout_d;
        end
    end

    assign core_rst_n   = core_rst_n_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_value    = res_value_q;
    assign res_state    = res_state_q;
    assign res_heap     = res_heap_q;
    assign res_heap_max = res_heap_max_q;
    assign res_cycles   = res_cycles_q;
    assign res_timeout  = res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_reduceron_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduceron_run_ctrl
// Brief    : Self-checking bench: default, timeout and narrow-counter instances.
// Revision : 1.0
// ============================================================================
module tb_reduceron_run_ctrl;
    import reduceron_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset_n, abort, res_ready, core_finish;
    logic               start_a, start_t, start_s;
    logic [RES_W-1:0]   core_result;
    logic [STATE_W-1:0] core_state;
    logic [HEAP_W-1:0]  core_heap;

    logic a_rst_n, a_busy, a_valid, a_to;
    logic t_rst_n, t_busy, t_valid, t_to;
    logic s_rst_n, s_busy, s_valid, s_to;
    logic [RES_W-1:0]   a_val, t_val, s_val;
    logic [STATE_W-1:0] a_st, t_st, s_st;
    logic [HEAP_W-1:0]  a_h, t_h, s_h, a_hm, t_hm, s_hm;
    logic [31:0]        a_cyc, t_cyc;
    logic [3:0]         s_cyc;

    reduceron_run_ctrl dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .abort(abort),
        .core_rst_n(a_rst_n), .core_finish(core_finish), .core_result(core_result),
        .core_state(core_state), .core_heap(core_heap), .busy(a_busy),
        .res_valid(a_valid), .res_ready(res_ready), .res_value(a_val),
        .res_state(a_st), .res_heap(a_h), .res_heap_max(a_hm),
        .res_cycles(a_cyc), .res_timeout(a_to)
    );

    reduceron_run_ctrl #(.MAX_CYCLES(50)) dut_t (
        .clock(clock), .reset_n(reset_n), .start(start_t), .abort(abort),
        .core_rst_n(t_rst_n), .core_finish(core_finish), .core_result(core_result),
        .core_state(core_state), .core_heap(core_heap), .busy(t_busy),
        .res_valid(t_valid), .res_ready(res_ready), .res_value(t_val),
        .res_state(t_st), .res_heap(t_h), .res_heap_max(t_hm),
        .res_cycles(t_cyc), .res_timeout(t_to)
    );

    reduceron_run_ctrl #(.RST_CYCLES(1), .CNT_W(4)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start_s), .abort(abort),
        .core_rst_n(s_rst_n), .core_finish(core_finish), .core_result(core_result),
        .core_state(core_state), .core_heap(core_heap), .busy(s_busy),
        .res_valid(s_valid), .res_ready(res_ready), .res_value(s_val),
        .res_state(s_st), .res_heap(s_h), .res_heap_max(s_hm),
        .res_cycles(s_cyc), .res_timeout(s_to)
    );

    // View of whichever instance is under test.
    int sel = 0;
    logic               m_rst_n, m_busy, m_valid, m_to;
    logic [RES_W-1:0]   m_val;
    logic [STATE_W-1:0] m_st;
    logic [HEAP_W-1:0]  m_h, m_hm;
    logic [31:0]        m_cyc;
    always_comb begin
        m_rst_n = a_rst_n; m_busy = a_busy; m_valid = a_valid; m_to = a_to;
        m_val = a_val; m_st = a_st; m_h = a_h; m_hm = a_hm; m_cyc = a_cyc;
        if (sel == 1) begin
            m_rst_n = t_rst_n; m_busy = t_busy; m_valid = t_valid; m_to = t_to;
            m_val = t_val; m_st = t_st; m_h = t_h; m_hm = t_hm; m_cyc = t_cyc;
        end else if (sel == 2) begin
            m_rst_n = s_rst_n; m_busy = s_busy; m_valid = s_valid; m_to = s_to;
            m_val = s_val; m_st = s_st; m_h = s_h; m_hm = s_hm; m_cyc = {28'd0, s_cyc};
        end
    end

    typedef struct {
        int              dut;
        int              len;
        bit              fin;
        logic [RES_W-1:0]   r;
        logic [STATE_W-1:0] s;
        int              step;
        int              peak;
        int              hend;
        int              exp_cyc;
        int              exp_max;
        bit              exp_to;
    } vec_t;

    typedef struct {
        logic [RES_W-1:0]   v;
        logic [STATE_W-1:0] s;
        logic [HEAP_W-1:0]  h;
        logic [HEAP_W-1:0]  hm;
        logic [31:0]        c;
        logic               to;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic int heap_at(input vec_t v, input int k);
        int h;
        if (k == v.len) return v.hend;
        h = (k - 1) * v.step;
        return (h > v.peak) ? v.peak : h;
    endfunction

    function automatic int rst_hold(input int which);
        return (which == 2) ? 1 : 4;
    endfunction

    // Values a controller must ignore outside RUN.
    task automatic idle_inputs();
        core_finish = 1'b1;
        core_result = '1;
        core_state  = '1;
        core_heap   = '1;
    endtask

    task automatic launch();
        case (sel)
            0:       start_a = 1'b1;
            1:       start_t = 1'b1;
            default: start_s = 1'b1;
        endcase
        @(negedge clock);
        start_a = 1'b0; start_t = 1'b0; start_s = 1'b0;
    endtask

    task automatic wait_run();
        int lows = 0;
        int guard = 0;
        while (m_rst_n !== 1'b1 && guard < 40) begin
            if (m_busy === 1'b1) lows++;
            guard++;
            @(negedge clock);
        end
        chk("rst_hold_cycles", lows, rst_hold(sel));
        chk("busy_in_run", {31'd0, m_busy}, 1);
    endtask

    task automatic collect();
        exp_t e;
        int guard = 0;
        while (m_valid !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clock);
        end
        chk("valid_latency", guard, 0);
        chk("sb_depth", sbq.size(), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("res_value", {14'd0, m_val}, {14'd0, e.v});
            chk("res_state", {25'd0, m_st}, {25'd0, e.s});
            chk("res_heap", {17'd0, m_h}, {17'd0, e.h});
            chk("res_heap_max", {17'd0, m_hm}, {17'd0, e.hm});
            chk("res_cycles", m_cyc, e.c);
            chk("res_timeout", {31'd0, m_to}, {31'd0, e.to});
        end
    endtask

    task automatic do_run(input vec_t v, input bit started);
        exp_t e;
        bit early = 1'b0;
        e.v = v.r; e.s = v.s; e.h = HEAP_W'(v.hend); e.hm = HEAP_W'(v.exp_max);
        e.c = v.exp_cyc; e.to = v.exp_to;
        sbq.push_back(e);
        sel = v.dut;
        if (!started) launch();
        wait_run();
        for (int k = 1; k <= v.len; k++) begin
            if (m_valid !== 1'b0) early = 1'b1;
            core_result = v.r;
            core_state  = v.s;
            core_finish = v.fin && (k == v.len);
            core_heap   = HEAP_W'(heap_at(v, k));
            @(negedge clock);
        end
        idle_inputs();
        chk("no_early_valid", {31'd0, early}, 0);
        collect();
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("valid_drop", {31'd0, m_valid}, 0);
        chk("idle_after_accept", {31'd0, m_busy}, 0);
    endtask

    task automatic run_plain(input int n);
        for (int k = 0; k < n; k++) begin
            core_finish = 1'b0;
            core_heap   = HEAP_W'(k);
            @(negedge clock);
        end
    endtask

    initial begin
        vec_t h, n;
        bit   hold_ok, bad;
        logic [RES_W-1:0]   hv;
        logic [HEAP_W-1:0]  hh, hhm;
        logic [31:0]        hc;

        //          dut len fin r          s      step peak hend  cyc max    to
        vecs[0] = '{0, 100, 1, 18'd12345,  7'h2a, 10,  900, 500,  100, 900,   0};
        vecs[1] = '{0, 1,   1, 18'd1,      7'h01, 0,   0,   33,   1,   33,    0};
        vecs[2] = '{0, 20,  1, 18'h3fffe,  7'h55, 100, 1500, 3000, 20, 3000,  0};
        vecs[3] = '{1, 50,  0, 18'd777,    7'h03, 5,   100, 77,   50,  100,   1};
        vecs[4] = '{1, 50,  1, 18'd888,    7'h04, 0,   0,   32766, 50, 32766, 0};
        vecs[5] = '{1, 10,  1, 18'd999,    7'h05, 1,   5,   2,    10,  5,     0};
        vecs[6] = '{2, 20,  1, 18'd4242,   7'h09, 2,   30,  1,    15,  30,    0};

        reset_n = 1'b0; abort = 1'b0; res_ready = 1'b0;
        start_a = 1'b0; start_t = 1'b0; start_s = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        sel = 0;
        chk("reset_core_rst_n", {31'd0, m_rst_n}, 0);
        chk("reset_busy", {31'd0, m_busy}, 0);
        chk("reset_valid", {31'd0, m_valid}, 0);
        chk("reset_value", {14'd0, m_val}, 0);
        chk("reset_cycles", m_cyc, 0);
        chk("reset_heap_max", {17'd0, m_hm}, 0);
        chk("reset_timeout", {31'd0, m_to}, 0);
        chk("reset_t_valid", {31'd0, t_valid}, 0);
        chk("reset_s_rst_n", {31'd0, s_rst_n}, 0);

        for (int i = 0; i < 7; i++) begin
            do_run(vecs[i], 1'b0);
            accept();
        end

        // Back-pressure: result held, start ignored, then ready+start together.
        h = '{0, 5, 1, 18'd555, 7'h06, 3, 100, 50, 5, 50, 0};
        n = '{0, 3, 1, 18'd321, 7'h02, 4, 8, 1, 3, 4, 0};
        do_run(h, 1'b0);
        hv = m_val; hh = m_h; hhm = m_hm; hc = m_cyc;
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            core_heap   = HEAP_W'($urandom);
            core_result = RES_W'($urandom);
            core_finish = k[0];
            start_a     = (k == 3);
            @(negedge clock);
            if (m_valid !== 1'b1 || m_val !== hv || m_h !== hh || m_hm !== hhm || m_cyc !== hc)
                hold_ok = 1'b0;
        end
        start_a = 1'b0;
        idle_inputs();
        chk("hold_stable", {31'd0, hold_ok}, 1);
        chk("hold_start_ignored", {31'd0, m_busy}, 0);
        res_ready = 1'b1; start_a = 1'b1;
        @(negedge clock);
        res_ready = 1'b0; start_a = 1'b0;
        chk("restart_valid_drop", {31'd0, m_valid}, 0);
        chk("restart_busy", {31'd0, m_busy}, 1);
        do_run(n, 1'b1);
        accept();

        // Abort during RUN.
        sel = 0;
        launch();
        wait_run();
        run_plain(3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        idle_inputs();
        chk("abort_run_busy", {31'd0, m_busy}, 0);
        chk("abort_run_rst_n", {31'd0, m_rst_n}, 0);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (m_valid !== 1'b0 || m_busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_run_quiet", {31'd0, bad}, 0);

        // Abort during DONE discards the pending result.
        do_run(vecs[1], 1'b0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_done_valid", {31'd0, m_valid}, 0);
        chk("abort_done_rst_n", {31'd0, m_rst_n}, 0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (m_valid !== 1'b0) bad = 1'b1;
        end
        chk("abort_done_discard", {31'd0, bad}, 0);

        // Asynchronous reset between edges while running.
        sel = 0;
        launch();
        wait_run();
        run_plain(4);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_core_rst_n", {31'd0, m_rst_n}, 0);
        chk("async_rst_busy", {31'd0, m_busy}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clock);
        chk("post_rst_valid", {31'd0, m_valid}, 0);
        chk("post_rst_cycles", m_cyc, 0);
        chk("post_rst_value", {14'd0, m_val}, 0);
        do_run(vecs[1], 1'b0);
        accept();

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
